// File: rtl/input_debouncer.sv
// Multi-channel two-flop synchronizer and debouncer for asynchronous board inputs.
// Produces a debounced level per channel plus registered single-cycle rise/fall pulses.
module input_debouncer #(
  parameter int               WIDTH         = 3,
  parameter int               STABLE_CYCLES = 120000,
  parameter logic [WIDTH-1:0] INIT_LEVEL    = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TERM_CNT = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1 || WIDTH < 1) begin : g_bad_params
    $error("input_debouncer: STABLE_CYCLES and WIDTH must both be at least 1");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // A channel is PENDING whenever its synchronized input disagrees with its level.
  logic [WIDTH-1:0] pending;
  assign pending = sync2_q ^ level_q;

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (pending[i]) begin
        if (cnt_q[i] == TERM_CNT) begin
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= INIT_LEVEL;
      sync2_q <= INIT_LEVEL;
      level_q <= INIT_LEVEL;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (WIDTH=3, STABLE_CYCLES=4): table vectors, hand sequences
// and random stimulus, all compared against a window-based reference model.
module tb_input_debouncer;

  localparam int W = 3;
  localparam int S = 4;

  // Clock / reset
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] level, rise, fall;

  always #5 clock = ~clock;

  input_debouncer #(.WIDTH(W), .STABLE_CYCLES(S), .INIT_LEVEL(3'b000)) dut (
    .clock (clock),
    .reset (reset),
    .raw_in(raw_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Reference model: level flips once the last S synchronized samples, all taken
  // since the previous flip, disagree with it.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] win_q[$];
  int           since [W];
  logic [W-1:0] m_level, m_rise, m_fall;
  logic [W-1:0] exp_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic model_reset();
    raw_hist.delete();
    raw_hist.push_back(3'b000);
    raw_hist.push_back(3'b000);
    win_q.delete();
    for (int c = 0; c < W; c++) since[c] = 0;
    m_level = 3'b000;
    m_rise  = 3'b000;
    m_fall  = 3'b000;
  endtask

  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] s2;
    logic         all_diff;
    s2 = raw_hist[0];
    void'(raw_hist.pop_front());
    raw_hist.push_back(r);
    win_q.push_back(s2);
    if (win_q.size() > S) void'(win_q.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < W; c++) begin
      since[c]++;
      if (since[c] >= S) begin
        all_diff = 1'b1;
        foreach (win_q[j]) if (win_q[j][c] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          m_rise[c]  = m_level[c];
          m_fall[c]  = ~m_level[c];
          since[c]   = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: apply raw for one edge, advance the model, compare #1 after the edge.
  task automatic step(input logic [W-1:0] r);
    raw_in = r;
    @(posedge clock);
    model_edge(r);
    #1;
    exp_q.push_back(m_level);
    chk("model_level", level, exp_q.pop_front());
    chk("model_rise", rise, m_rise);
    chk("model_fall", fall, m_fall);
    chk("rise_and_fall", rise & fall, 3'b000);
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] lvl;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int           first;
    int           npulse;
    logic         ever;
    logic [W-1:0] rv;
    int           hold;

    // Press on ch0 (capture at entry 0, flip at entry 5), then release.
    for (int i = 0; i < 7; i++) begin
      tbl[i].raw = 3'b001;
      tbl[i].lvl = (i >= 5) ? 3'b001 : 3'b000;
      tbl[i].rs  = (i == 5) ? 3'b001 : 3'b000;
      tbl[i].fl  = 3'b000;
    end
    for (int i = 7; i < 14; i++) begin
      tbl[i].raw = 3'b000;
      tbl[i].lvl = (i >= 12) ? 3'b000 : 3'b001;
      tbl[i].rs  = 3'b000;
      tbl[i].fl  = (i == 12) ? 3'b001 : 3'b000;
    end

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_level", level, 3'b000);
    chk("reset_rise", rise, 3'b000);
    chk("reset_fall", fall, 3'b000);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(3'b000);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].raw);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_rise", i), rise, tbl[i].rs);
      chk($sformatf("tbl%0d_fall", i), fall, tbl[i].fl);
    end

    // Bounce on ch1: 1,0,1,0 two cycles each, then 1 held from step 8.
    first = -1; npulse = 0;
    for (int i = 0; i < 18; i++) begin
      rv = (i >= 8) ? 3'b010 : ((((i / 2) % 2) == 0) ? 3'b010 : 3'b000);
      step(rv);
      if (rise[1]) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    chk("bounce_pulses", W'(npulse), 3'd1);
    chk("bounce_latency", W'(first), W'(8 + 1 + S));
    repeat (8) step(3'b000);

    // Glitch on ch2 shorter than the threshold.
    ever = 1'b0; npulse = 0;
    for (int i = 0; i < 10; i++) begin
      step((i < 3) ? 3'b100 : 3'b000);
      if (level[2] || rise[2] || fall[2]) ever = 1'b1;
    end
    chk("glitch_activity", {2'b00, ever}, 3'b000);

    // Simultaneous transition on ch0 and ch2.
    first = -1;
    for (int i = 0; i < 8; i++) begin
      step(3'b101);
      if (rise != 3'b000 && first < 0) begin
        first = i;
        chk("simul_rise", rise, 3'b101);
        chk("simul_level", level, 3'b101);
      end
    end
    chk("simul_latency", W'(first), W'(1 + S));
    repeat (8) step(3'b000);

    // Random stimulus with random hold lengths.
    for (int i = 0; i < 60; i++) begin
      rv   = W'($urandom_range(0, 7));
      hold = $urandom_range(1, 7);
      repeat (hold) step(rv);
    end

    // Reset mid-count: ch1 settled high, ch0 two counts into a rise.
    repeat (8) step(3'b010);
    repeat (4) step(3'b011);
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_clr_level", level, 3'b000);
    chk("async_clr_rise", rise, 3'b000);
    chk("async_clr_fall", fall, 3'b000);
    @(negedge clock);
    reset = 1'b1;
    first = -1; npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      step(3'b011);
      if (rise[0]) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    chk("rst_rise_pulses", W'(npulse), 3'd1);
    chk("rst_rise_edge", W'(first), W'(2 + S));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
